// File: rtl/pnr_sys_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : pnr_sys_bus_master_if
// Purpose  : PNR system-bus signal bundle with initiator/responder modports.
// Revision : 1.0 - initial release
// ============================================================================
interface pnr_sys_bus_master_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface
`default_nettype wire

// File: rtl/pnr_sys_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : pnr_sys_bus_master
// Purpose  : Single-command system-bus initiator with ack timeout and a
//            valid/ready response channel. Optional PNR_SYS_BUS_MASTER_RETRY_EN
//            re-issues a failed transfer once and flags it on rsp_retried_o.
// Revision : 1.0 - initial release
// ============================================================================
module pnr_sys_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ADDR_MASK      = 32'h000F_FFFF
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
    output logic        rsp_retried_o,
`endif
    pnr_sys_bus_master_if.master sys
);

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_we;
    logic [15:0] r_cnt;
    logic [31:0] r_sys_addr;
    logic [31:0] r_sys_wdata;
    logic        r_sys_wen;
    logic        r_sys_ren;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_timeout;

    logic        w_done;
    logic        w_fail;
    logic        w_can_retry;

    // A transfer ends on ack, or on the last allowed WAIT cycle without one.
    assign w_done = sys.sys_ack | (r_cnt == c_TMO_LAST);
    assign w_fail = ~sys.sys_ack | sys.sys_err;

`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
    logic r_retried;
    logic r_rsp_retried;
    assign w_can_retry   = ~r_retried;
    assign rsp_retried_o = r_rsp_retried;
`else
    assign w_can_retry   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_we          <= 1'b0;
            r_cnt         <= 16'd0;
            r_sys_addr    <= 32'd0;
            r_sys_wdata   <= 32'd0;
            r_sys_wen     <= 1'b0;
            r_sys_ren     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
            r_retried     <= 1'b0;
            r_rsp_retried <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_we        <= cmd_we_i;
                        r_sys_addr  <= cmd_addr_i & ADDR_MASK;
                        r_sys_wdata <= cmd_we_i ? cmd_wdata_i : 32'd0;
                        r_sys_wen   <= cmd_we_i;
                        r_sys_ren   <= ~cmd_we_i;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_ISSUE;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
                        r_retried   <= 1'b0;
`endif
                    end
                end

                S_ISSUE: begin
                    // Strobe lasts exactly this cycle; any ack seen here is ignored.
                    r_sys_wen <= 1'b0;
                    r_sys_ren <= 1'b0;
                    r_cnt     <= 16'd0;
                    r_state   <= S_WAIT;
                end

                S_WAIT: begin
                    if (w_done) begin
                        if (w_fail && w_can_retry) begin
                            r_sys_wen <= r_we;
                            r_sys_ren <= ~r_we;
                            r_state   <= S_ISSUE;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
                            r_retried <= 1'b1;
`endif
                        end else begin
                            r_rsp_valid   <= 1'b1;
                            r_rsp_rdata   <= (sys.sys_ack && !r_we && !sys.sys_err) ?
                                             sys.sys_rdata : 32'd0;
                            r_rsp_err     <= sys.sys_ack & sys.sys_err;
                            r_rsp_timeout <= ~sys.sys_ack;
                            r_sys_addr    <= 32'd0;
                            r_sys_wdata   <= 32'd0;
                            r_state       <= S_RESP;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
                            r_rsp_retried <= r_retried;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_rdata   <= 32'd0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_state       <= S_IDLE;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
                        r_rsp_retried <= 1'b0;
`endif
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;
    assign sys.sys_addr  = r_sys_addr;
    assign sys.sys_wdata = r_sys_wdata;
    assign sys.sys_wen   = r_sys_wen;
    assign sys.sys_ren   = r_sys_ren;

endmodule
`default_nettype wire

// File: tb/tb_pnr_sys_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_pnr_sys_bus_master
// Purpose  : Directed vector bench for pnr_sys_bus_master with a model responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pnr_sys_bus_master;

    localparam int M_OK    = 0;
    localparam int M_ERR   = 1;
    localparam int M_NOACK = 2;
    localparam int M_RETRY = 3;

`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
    localparam int LAT_TMO = 11;
    localparam int LAT_ERR = 5;
    localparam int P_FAIL  = 2;
`else
    localparam int LAT_TMO = 6;
    localparam int LAT_ERR = 3;
    localparam int P_FAIL  = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_we, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
    logic        rsp_retried;
`endif
    logic        last_retried;

    int n_checks = 0;
    int n_errors = 0;

    pnr_sys_bus_master_if bus();

    pnr_sys_bus_master #(
        .TIMEOUT_CYCLES (4),
        .ADDR_MASK      (32'h000F_FFFF)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
        .rsp_retried_o (rsp_retried),
`endif
        .sys           (bus)
    );

    always #5 clk = ~clk;

    // Model responder: registered ack one cycle after the strobe.
    int          resp_mode = M_OK;
    int          skip_at   = -1;
    int          strobe_cnt = 0;
    logic        inj_ack = 1'b0;
    logic        r_ack = 1'b0, r_err = 1'b0;
    logic [31:0] r_rdata = 32'd0;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        r_ack   <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
        if (bus.sys_wen || bus.sys_ren) begin
            strobe_cnt <= strobe_cnt + 1;
            case (resp_mode)
                M_OK: begin
                    r_ack <= 1'b1;
                    if (bus.sys_wen && bus.sys_addr < 32'h40)
                        mem[bus.sys_addr[5:2]] <= bus.sys_wdata;
                    if (bus.sys_ren)
                        r_rdata <= (bus.sys_addr < 32'h40) ? mem[bus.sys_addr[5:2]] : 32'd0;
                end
                M_ERR: begin
                    r_ack <= 1'b1;
                    r_err <= 1'b1;
                end
                M_RETRY: begin
                    if (strobe_cnt != skip_at) begin
                        r_ack   <= 1'b1;
                        r_rdata <= 32'h3FFF;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sys_ack   = r_ack | inj_ack;
    assign bus.sys_err   = r_err;
    assign bus.sys_rdata = r_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command, return at the first cycle rsp_valid is seen (lat counts
    // cycles from accept) and, when rsp_ready is high, sample cmd_ready one cycle later.
    task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int wen_p, output int ren_p,
                           output logic [31:0] saddr, output logic [31:0] swdata,
                           output logic [31:0] rdata, output logic err, output logic tmo,
                           output logic rdy_after);
        int n;
        lat = 0; wen_p = 0; ren_p = 0; saddr = 32'hX; swdata = 32'hX;
        rdata = 32'hX; err = 1'bX; tmo = 1'bX; rdy_after = 1'bX;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            if ((bus.sys_wen || bus.sys_ren) && wen_p == 0 && ren_p == 0) begin
                saddr  = bus.sys_addr;
                swdata = bus.sys_wdata;
            end
            if (bus.sys_wen) wen_p++;
            if (bus.sys_ren) ren_p++;
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        tmo   = rsp_timeout;
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
        last_retried = rsp_retried;
`else
        last_retried = 1'b0;
`endif
        if (rsp_ready) begin
            @(negedge clk);
            rdy_after = cmd_ready;
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          mode;
        logic [31:0] exp_saddr;
        logic [31:0] exp_swdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    vec_t tbl [8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int          lat, wen_p, ren_p, n;
        logic [31:0] saddr, swdata, rdata;
        logic        err, tmo, rdy;

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h0000_01A5, M_OK,    32'h0, 32'h1A5,      32'h0,        1'b0, 1'b0, 3,       1};
        tbl[1] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, M_OK,    32'h0, 32'h0,        32'h1A5,      1'b0, 1'b0, 3,       1};
        tbl[2] = '{1'b0, 32'h0000_0040, 32'h0,         M_OK,    32'h40, 32'h0,       32'h0,        1'b0, 1'b0, 3,       1};
        tbl[3] = '{1'b1, 32'h4010_0008, 32'hDEAD_BEEF, M_OK,    32'h8, 32'hDEAD_BEEF, 32'h0,       1'b0, 1'b0, 3,       1};
        tbl[4] = '{1'b0, 32'h0000_0008, 32'h0,         M_OK,    32'h8, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 3,      1};
        tbl[5] = '{1'b0, 32'h0000_0004, 32'h0,         M_NOACK, 32'h4, 32'h0,        32'h0,        1'b0, 1'b1, LAT_TMO, P_FAIL};
        tbl[6] = '{1'b1, 32'h0000_000C, 32'h0000_1234, M_ERR,   32'hC, 32'h1234,     32'h0,        1'b1, 1'b0, LAT_ERR, P_FAIL};
        tbl[7] = '{1'b0, 32'h0000_000C, 32'h0,         M_ERR,   32'hC, 32'h0,        32'h0,        1'b1, 1'b0, LAT_ERR, P_FAIL};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_err, rsp_timeout}, 32'd0);
        chk("rst_sys_en",    {30'd0, bus.sys_wen, bus.sys_ren}, 32'd0);
        chk("rst_sys_addr",  bus.sys_addr, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            resp_mode = tbl[i].mode;
            run_cmd(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, wen_p, ren_p,
                    saddr, swdata, rdata, err, tmo, rdy);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("v%0d_wen_pulses", i), wen_p, tbl[i].we ? tbl[i].exp_pulses : 0);
            chk($sformatf("v%0d_ren_pulses", i), ren_p, tbl[i].we ? 0 : tbl[i].exp_pulses);
            chk($sformatf("v%0d_sys_addr", i), saddr, tbl[i].exp_saddr);
            chk($sformatf("v%0d_sys_wdata", i), swdata, tbl[i].exp_swdata);
            chk($sformatf("v%0d_rsp_rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("v%0d_rsp_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
            chk($sformatf("v%0d_rsp_timeout", i), {31'd0, tmo}, {31'd0, tbl[i].exp_tmo});
            chk($sformatf("v%0d_ready_after", i), {31'd0, rdy}, 32'd1);
`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
            chk($sformatf("v%0d_retried", i), {31'd0, last_retried},
                {31'd0, (tbl[i].mode != M_OK)});
`endif
        end

        // Late ack after a timeout must not create a response.
        resp_mode = M_NOACK;
        run_cmd(1'b0, 32'h4, 32'h0, lat, wen_p, ren_p, saddr, swdata, rdata, err, tmo, rdy);
        chk("late_tmo_flag", {31'd0, tmo}, 32'd1);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid || bus.sys_wen || bus.sys_ren) n++;
            @(negedge clk);
        end
        chk("late_ack_ignored", n, 0);
        chk("late_ack_ready", {31'd0, cmd_ready}, 32'd1);
        resp_mode = M_OK;
        run_cmd(1'b0, 32'h0, 32'h0, lat, wen_p, ren_p, saddr, swdata, rdata, err, tmo, rdy);
        chk("after_late_rdata", rdata, 32'h1A5);
        chk("after_late_latency", lat, 3);

        // Back-pressure with an error response.
        rsp_ready = 1'b0;
        resp_mode = M_ERR;
        run_cmd(1'b1, 32'h10, 32'h55, lat, wen_p, ren_p, saddr, swdata, rdata, err, tmo, rdy);
        resp_mode = M_OK;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_err_%0d", k), {31'd0, rsp_err}, 32'd1);
            chk($sformatf("bp_tmo_%0d", k), {31'd0, rsp_timeout}, 32'd0);
            chk($sformatf("bp_ready_%0d", k), {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("bp_ready_at_release", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_accepted", {31'd0, cmd_ready}, 32'd0);
        chk("bp_next_ren", {31'd0, bus.sys_ren}, 32'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_next_wait", n, 2);
        chk("bp_next_rdata", rsp_rdata, 32'h1A5);

        // Reset while in WAIT, plus address masking on the strobe.
        resp_mode = M_NOACK;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4010_0008;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mask_ren", {31'd0, bus.sys_ren}, 32'd1);
        chk("mask_addr", bus.sys_addr, 32'h0000_0008);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_en", {30'd0, bus.sys_wen, bus.sys_ren}, 32'd0);
        chk("midrst_addr", bus.sys_addr, 32'd0);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid || bus.sys_wen || bus.sys_ren) n++;
            @(negedge clk);
        end
        chk("midrst_stale_ack", n, 0);

`ifdef PNR_SYS_BUS_MASTER_RETRY_EN
        // First strobe times out, second is acked with data.
        resp_mode = M_RETRY;
        skip_at   = strobe_cnt;
        run_cmd(1'b0, 32'h10, 32'h0, lat, wen_p, ren_p, saddr, swdata, rdata, err, tmo, rdy);
        chk("retry_ren_pulses", ren_p, 2);
        chk("retry_wen_pulses", wen_p, 0);
        chk("retry_rdata", rdata, 32'h3FFF);
        chk("retry_timeout", {31'd0, tmo}, 32'd0);
        chk("retry_err", {31'd0, err}, 32'd0);
        chk("retry_flag", {31'd0, last_retried}, 32'd1);
        chk("retry_latency", lat, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
